ecc_scrub_ram: RTL and testbench

ECC_SCRUB_RAM -- requirements
Module: ecc_scrub_ram

---
 rtl/ecc_pkg.sv | 83 ++++++++
 rtl/secded_dec.sv | 58 +++++
 rtl/ecc_scrub_ram.sv | 183 ++++++++++++++++++
 tb/tb_ecc_scrub_ram.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the scrubbing RAM: code geometry,
// Hamming bit placement, the encoder and the scrub FSM state type.
package ecc_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_CW_W   = 72;
    localparam int MAX_HAM_N  = MAX_CW_W - 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WB_PEND = 1'b1
    } scrub_state_t;

    // Number of Hamming check bits: smallest p with 2**p >= dw + p + 1.
    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int k = 1; k <= 8; k++) begin
            if (p == 0 && (1 << k) >= dw + k + 1) begin
                p = k;
            end
        end
        return p;
    endfunction

    // Hamming check bits plus one overall parity bit.
    function automatic int calc_chk_w(input int dw);
        return calc_p(dw) + 1;
    endfunction

    function automatic int calc_cw_w(input int dw);
        return dw + calc_chk_w(dw);
    endfunction

    // Syndrome-position table: codeword bit k (k >= 1) is Hamming position k,
    // check bits sit at powers of two, data bits fill the remaining positions
    // in ascending order. Codeword bit 0 is the overall parity bit.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = -1;
        pos = 0;
        for (int k = 1; k <= MAX_HAM_N; k++) begin
            if ((k & (k - 1)) != 0 && cnt < idx) begin
                cnt = cnt + 1;
                pos = k;
            end
        end
        return pos;
    endfunction

    // SECDED encoder; the caller truncates the result to its own codeword width.
    function automatic logic [MAX_CW_W-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                   input int dw);
        logic [MAX_CW_W-1:0] cw;
        logic                b;
        int                  p;
        int                  n;
        p  = calc_p(dw);
        n  = dw + p;
        cw = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < dw) begin
                cw[data_pos(i)] = data[i];
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (j < p) begin
                b = 1'b0;
                for (int k = 1; k < MAX_CW_W; k++) begin
                    if (k <= n && (k & (1 << j)) != 0) begin
                        b = b ^ cw[k];
                    end
                end
                cw[1 << j] = b;
            end
        end
        // Overall parity makes the whole codeword even.
        cw[0] = ^cw;
        return cw;
    endfunction

endpackage

// File: rtl/secded_dec.sv
// Combinational SECDED decoder: syndrome, single-bit correction and
// classification of the read codeword into clean / corrected / uncorrectable.
module secded_dec
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int CW_W   = calc_cw_w(DATA_W)
)(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic              err_corr,
    output logic              err_uncorr
);

    localparam int P_W = calc_p(DATA_W);

    logic [P_W-1:0]  syndrome;
    logic            parity_bad;
    logic [CW_W-1:0] fixed_cw;

    // Syndrome is the XOR of the positions of every set Hamming bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        syndrome = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (cw[k]) begin
                syndrome = syndrome ^ k[P_W-1:0];
            end
        end
        parity_bad = ^cw;
    end

    // Classify the error and flip the bit the syndrome points at.
    always_comb begin
        fixed_cw   = cw;
        err_corr   = 1'b0;
        err_uncorr = 1'b0;
        data       = '0;
        if (parity_bad) begin
            // Odd error count: a zero syndrome means the overall parity bit
            // itself flipped, so no data position is touched.
            err_corr = 1'b1;
            for (int k = 1; k < CW_W; k++) begin
                if (syndrome == k[P_W-1:0]) begin
                    fixed_cw[k] = ~cw[k];
                end
            end
        end else if (syndrome != '0) begin
            // Even error count with a nonzero syndrome: two bits flipped,
            // nothing is corrected and the raw data bits are passed through.
            err_uncorr = 1'b1;
        end
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = fixed_cw[data_pos(i)];
        end
    end

endmodule

// File: rtl/ecc_scrub_ram.sv
// SECDED-protected RAM with a two-stage read pipeline and a one-deep
// scrubber that writes corrected words back when the write port is free.
module ecc_scrub_ram
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 4,
    localparam int CHK_W  = calc_chk_w(DATA_W),
    localparam int CW_W   = DATA_W + CHK_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CW_W-1:0]   inj_mask,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic              wb_busy,
    output logic [15:0]       corr_count,
    output logic [7:0]        uncorr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [CW_W-1:0]   mem [DEPTH];

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [CW_W-1:0]   s1_cw;

    logic [DATA_W-1:0] dec_data;
    logic              dec_corr;
    logic              dec_uncorr;
    logic [ADDR_W-1:0] out_addr;

    scrub_state_t      state;
    scrub_state_t      state_nxt;
    logic              wb_fire;
    logic              wb_capture;
    logic [ADDR_W-1:0] wb_addr;
    logic [CW_W-1:0]   wb_cw;

    logic [CW_W-1:0]   user_cw;
    logic [CW_W-1:0]   clean_cw;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [CW_W-1:0]   mem_wdata;

    // Encoders for the user write path and for re-encoding corrected read data.
    always_comb begin
        user_cw  = CW_W'(encode(MAX_DATA_W'(wr_data), DATA_W)) ^ inj_mask;
        clean_cw = CW_W'(encode(MAX_DATA_W'(rd_data), DATA_W));
    end

    // Single write port: user writes always win, write-back uses idle slots.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = user_cw;
        if (!rst) begin
            if (wr_en) begin
                mem_we = 1'b1;
            end else if (wb_fire) begin
                mem_we    = 1'b1;
                mem_waddr = wb_addr;
                mem_wdata = wb_cw;
            end
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents must survive rst and a RAM macro cannot be cleared in one cycle.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read stage 1: fetch the stored codeword (old data on a same-address write).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_cw    <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_addr <= rd_addr;
                s1_cw   <= mem[rd_addr];
            end
        end
    end

    secded_dec #(
        .DATA_W     (DATA_W)
    ) u_dec (
        .cw         (s1_cw),
        .data       (dec_data),
        .err_corr   (dec_corr),
        .err_uncorr (dec_uncorr)
    );

    // Read stage 2: register decoded data, flags and saturating error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            err_corr     <= 1'b0;
            err_uncorr   <= 1'b0;
            out_addr     <= '0;
            corr_count   <= '0;
            uncorr_count <= '0;
        end else begin
            rd_valid   <= s1_valid;
            err_corr   <= s1_valid & dec_corr;
            err_uncorr <= s1_valid & dec_uncorr;
            if (s1_valid) begin
                rd_data  <= dec_data;
                out_addr <= s1_addr;
                if (dec_corr && corr_count != 16'hFFFF) begin
                    corr_count <= corr_count + 16'd1;
                end
                if (dec_uncorr && uncorr_count != 8'hFF) begin
                    uncorr_count <= uncorr_count + 8'd1;
                end
            end
        end
    end

    // Scrub FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scrub FSM next state: capture on a corrected read, write back when the
    // port is free, drop the pending word if the user overwrites its address.
    always_comb begin
        state_nxt  = state;
        wb_fire    = 1'b0;
        wb_capture = 1'b0;
        case (state)
            IDLE: begin
                if (rd_valid && err_corr) begin
                    wb_capture = 1'b1;
                    state_nxt  = WB_PEND;
                end
            end
            WB_PEND: begin
                if (!wr_en) begin
                    wb_fire   = 1'b1;
                    state_nxt = IDLE;
                end else if (wr_addr == wb_addr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-back slot: address and re-encoded corrected word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr <= '0;
            wb_cw   <= '0;
        end else if (wb_capture) begin
            wb_addr <= out_addr;
            wb_cw   <= clean_cw;
        end
    end

    assign wb_busy = (state == WB_PEND);

endmodule

// File: tb/tb_ecc_scrub_ram.sv
// Self-checking bench for ecc_scrub_ram: a word-level model tracks stored data
// plus an injected-error mask per address and predicts every output each cycle.
module tb_ecc_scrub_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int CW_W   = 13;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [CW_W-1:0]   inj_mask = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              err_corr;
    logic              err_uncorr;
    logic              wb_busy;
    logic [15:0]       corr_count;
    logic [7:0]        uncorr_count;

    always #5 clk = ~clk;

    ecc_scrub_ram #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .inj_mask     (inj_mask),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .err_corr     (err_corr),
        .err_uncorr   (err_uncorr),
        .wb_busy      (wb_busy),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       valid;
        logic [3:0] addr;
        logic [7:0] data;
        logic       corr;
        logic       uncorr;
    } rd_res_t;

    // Codeword positions holding data bits 0..7 (bit 0 = overall parity,
    // powers of two = check bits).
    int dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    logic [7:0]  m_data [DEPTH];
    logic [12:0] m_mask [DEPTH];
    rd_res_t     m_pend = '0;
    rd_res_t     m_out  = '0;
    int          m_corr = 0;
    int          m_uncorr = 0;
    logic        m_busy = 1'b0;
    logic [3:0]  m_wb_addr = '0;
    logic [7:0]  m_wb_data = '0;
    bit          cmp_en = 1'b0;

    // One flipped bit is always correctable; two flipped bits are reported
    // with the data bits they hit left flipped.
    function automatic rd_res_t model_read(input logic [3:0] a);
        rd_res_t r;
        int      ones;
        ones     = $countones(m_mask[a]);
        r.valid  = 1'b1;
        r.addr   = a;
        r.data   = m_data[a];
        r.corr   = (ones == 1);
        r.uncorr = (ones == 2);
        if (ones == 2) begin
            for (int i = 0; i < 8; i++) begin
                if (m_mask[a][dpos[i]]) r.data[i] = ~r.data[i];
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        rd_res_t rnew;
        logic    busy_before;
        rnew = '0;
        if (rst) begin
            m_pend   = '0;
            m_out    = '0;
            m_corr   = 0;
            m_uncorr = 0;
            m_busy   = 1'b0;
        end else begin
            if (rd_en) rnew = model_read(rd_addr);
            busy_before = m_busy;
            if (busy_before) begin
                if (!wr_en) begin
                    m_data[m_wb_addr] = m_wb_data;
                    m_mask[m_wb_addr] = '0;
                    m_busy = 1'b0;
                end else if (wr_addr == m_wb_addr) begin
                    m_busy = 1'b0;
                end
            end
            if (wr_en) begin
                m_data[wr_addr] = wr_data;
                m_mask[wr_addr] = inj_mask;
            end
            if (!busy_before && m_out.valid && m_out.corr) begin
                m_busy    = 1'b1;
                m_wb_addr = m_out.addr;
                m_wb_data = m_out.data;
            end
            if (m_pend.valid) begin
                m_out = m_pend;
            end else begin
                m_out.valid  = 1'b0;
                m_out.corr   = 1'b0;
                m_out.uncorr = 1'b0;
            end
            m_pend = rnew;
            if (m_out.valid && m_out.corr && m_corr < 65535) m_corr++;
            if (m_out.valid && m_out.uncorr && m_uncorr < 255) m_uncorr++;
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd_valid", rd_valid, m_out.valid);
            check("wb_busy", wb_busy, m_busy);
            check("corr_count", corr_count, m_corr);
            check("uncorr_count", uncorr_count, m_uncorr);
            if (m_out.valid) begin
                check("rd_data", rd_data, m_out.data);
                check("err_corr", err_corr, m_out.corr);
                check("err_uncorr", err_uncorr, m_out.uncorr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        inj_mask = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [12:0] m);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        inj_mask = m;
        tick();
        idle();
    endtask

    // Leaves the bench in the cycle where rd_valid for this read is high.
    task automatic do_read(input logic [3:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    function automatic logic [12:0] rand_mask();
        logic [12:0] m;
        int          k;
        int          b1;
        int          b2;
        m  = '0;
        k  = $urandom_range(0, 2);
        b1 = $urandom_range(0, 12);
        b2 = (b1 + 1 + $urandom_range(0, 11)) % 13;
        if (k >= 1) m[b1] = 1'b1;
        if (k == 2) m[b2] = 1'b1;
        return m;
    endfunction

    initial begin
        int pulses;

        rst = 1'b1;
        repeat (3) tick();
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset wb_busy", wb_busy, 0);
        check("reset corr_count", corr_count, 0);
        check("reset uncorr_count", uncorr_count, 0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        for (int a = 0; a < DEPTH; a++) do_write(a[3:0], 8'($urandom), '0);

        // Clean write/read, latency 2.
        do_write(4'd3, 8'hA5, '0);
        do_read(4'd3);
        check("clean rd_valid", rd_valid, 1);
        check("clean rd_data", rd_data, 8'hA5);
        check("clean err_corr", err_corr, 0);
        check("clean err_uncorr", err_uncorr, 0);
        check("clean corr_count", corr_count, 0);
        tick();
        check("rd_valid one cycle", rd_valid, 0);

        // Single-bit error: corrected, one-cycle write-back, re-read clean.
        do_write(4'd5, 8'h3C, 13'h0004);
        do_read(4'd5);
        check("single rd_data", rd_data, 8'h3C);
        check("single err_corr", err_corr, 1);
        check("single corr_count", corr_count, 1);
        tick();
        check("single wb_busy", wb_busy, 1);
        tick();
        check("single wb_busy done", wb_busy, 0);
        do_read(4'd5);
        check("scrubbed err_corr", err_corr, 0);
        check("scrubbed rd_data", rd_data, 8'h3C);

        // Double-bit error: data bits 0 and 4 flipped, no write-back.
        do_write(4'd5, 8'h3C, 13'h0208);
        do_read(4'd5);
        check("double rd_data raw", rd_data, 8'h2D);
        check("double err_uncorr", err_uncorr, 1);
        check("double uncorr_count", uncorr_count, 1);
        tick();
        check("double no wb", wb_busy, 0);
        do_read(4'd5);
        check("double reread err_uncorr", err_uncorr, 1);
        check("double reread uncorr_count", uncorr_count, 2);

        // Write-back deferred by user writes to another address.
        do_write(4'd7, 8'h5A, 13'h0040);
        do_read(4'd7);
        check("defer err_corr", err_corr, 1);
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h11;
        repeat (4) tick();
        check("defer wb_busy held", wb_busy, 1);
        idle();
        tick();
        check("defer wb done", wb_busy, 0);
        do_read(4'd7);
        check("defer reread clean", err_corr, 0);
        check("defer reread data", rd_data, 8'h5A);

        // Write-back cancelled by a user write to the same address.
        do_write(4'd7, 8'h5A, 13'h0040);
        do_read(4'd7);
        tick();
        check("cancel wb_busy", wb_busy, 1);
        do_write(4'd7, 8'h77, '0);
        check("cancel wb idle", wb_busy, 0);
        do_read(4'd7);
        check("cancel new data", rd_data, 8'h77);
        check("cancel no flag", err_corr, 0);

        // Streaming reads of all 16 addresses.
        pulses = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_en   = 1'b1;
            rd_addr = a[3:0];
            tick();
            if (rd_valid) pulses++;
        end
        idle();
        repeat (2) begin
            tick();
            if (rd_valid) pulses++;
        end
        check("stream pulses", pulses, 16);

        // Reset mid-stream with a write-back pending and a write under reset.
        do_write(4'd11, 8'h99, 13'h0001);
        do_read(4'd11);
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'h42;
        for (int a = 0; a < 6; a++) begin
            rd_en   = 1'b1;
            rd_addr = a[3:0];
            tick();
        end
        rst     = 1'b1;
        wr_addr = 4'd9;
        wr_data = 8'hEE;
        tick();
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 0);
        check("rst err_corr", err_corr, 0);
        check("rst err_uncorr", err_uncorr, 0);
        check("rst wb_busy", wb_busy, 0);
        check("rst corr_count", corr_count, 0);
        check("rst uncorr_count", uncorr_count, 0);
        rst = 1'b0;
        idle();
        do_read(4'd11);
        check("rst cancelled wb", err_corr, 1);
        check("rst kept data", rd_data, 8'h99);
        tick();
        tick();
        do_read(4'd9);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = 4'($urandom);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 4'($urandom);
            wr_data  = 8'($urandom);
            inj_mask = rand_mask();
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (4) tick();

        // Uncorrectable counter saturation.
        do_write(4'd4, 8'h0F, 13'h0006);
        rd_en   = 1'b1;
        rd_addr = 4'd4;
        repeat (260) tick();
        idle();
        repeat (3) tick();
        check("uncorr saturate", uncorr_count, 8'hFF);

        // Corrected counter saturation; write-back held off by user writes.
        do_write(4'd6, 8'hC3, 13'h0800);
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        rd_en   = 1'b1;
        rd_addr = 4'd6;
        repeat (65540) tick();
        rd_en = 1'b0;
        repeat (3) tick();
        check("corr saturate held wb", wb_busy, 1);
        idle();
        repeat (3) tick();
        check("corr saturate", corr_count, 16'hFFFF);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
